// File: rtl/enc_pkg.sv
// enc_pkg: shared definitions for the one-hot encode/decode pair.
//   ENC_W     - binary code width
//   ENC_N     - one-hot width (2^ENC_W - 1); the all-zero word encodes CODE_NONE
//   code_t    - binary code type
//   onehot_t  - one-hot word type
//   CODE_NONE - code carried by an all-zero one-hot word
package enc_pkg;

    localparam int ENC_W = 4;
    localparam int ENC_N = 15;

    typedef logic [ENC_W-1:0] code_t;
    typedef logic [ENC_N-1:0] onehot_t;

    localparam code_t CODE_NONE = code_t'((1 << ENC_W) - 1);

endpackage

// File: rtl/onehot_prio_idx.sv
// onehot_prio_idx: combinational lowest-set-bit finder for a one-hot word.
// Ports:
//   vec   in  N  one-hot (or malformed) word
//   idx   out W  index of the lowest set bit (all ones when no bit is set)
//   any   out 1  at least one bit set
//   multi out 1  two or more bits set
module onehot_prio_idx
    import enc_pkg::*;
#(
    parameter int W = ENC_W,
    parameter int N = ENC_N
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         multi
);

    always_comb begin
        idx = '1;
        // Scan from the top down so the last hit is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |vec;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/dec_onehot2bin.sv
// dec_onehot2bin: registered one-hot to binary converter with malformed-word
// detection and a saturating error counter. Single-entry pipeline register.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, in_ready = !out_valid || out_ready.
// Ports:
//   clk       in   1     clock, rising edge
//   rst       in   1     synchronous active-low reset
//   in_valid  in   1     upstream word valid
//   in_ready  out  1     block can accept a word this cycle
//   in        in   N     one-hot word
//   out_valid out  1     out/out_err hold a result (also the EMPTY/FULL state)
//   out_ready in   1     downstream accepts the result
//   out       out  W     decoded index (lowest set bit; all ones for all-zero)
//   out_err   out  1     result came from a multi-hot word
//   err_cnt   out  CNTW  saturating count of accepted multi-hot words
//   err_clr   in   1     synchronous clear of err_cnt (wins over increment)
module dec_onehot2bin
    import enc_pkg::*;
#(
    parameter int W    = ENC_W,
    parameter int N    = ENC_N,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out,
    output logic            out_err,
    output logic [CNTW-1:0] err_cnt,
    input  logic            err_clr
);

    logic [W-1:0] lo_idx;
    logic         lo_any;
    logic         lo_multi;
    logic         accept;

    onehot_prio_idx #(
        .W (W),
        .N (N)
    ) u_prio (
        .vec   (in),
        .idx   (lo_idx),
        .any   (lo_any),
        .multi (lo_multi)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // out_valid is the whole state: 0 = EMPTY, 1 = FULL.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            // All-zero is the legal encoding of the top code, not an error.
            out       <= lo_any ? lo_idx : '1;
            out_err   <= lo_multi;
        end else if (out_ready) begin
            // Transfer without a new word: data is left as don't-care.
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (accept && lo_multi && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_dec_onehot2bin.sv
// tb_dec_onehot2bin: directed vector table plus hand-written sequences for
// backpressure, saturation, mid-transfer reset, and a random stream against a
// reference decoder with an expected queue.
module tb_dec_onehot2bin;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out;
    logic        out_err;
    logic [7:0]  err_cnt;
    logic        err_clr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [14:0] in;
        logic [3:0]  out;
        logic        err;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[18];
    logic [4:0] exp_q[$];

    dec_onehot2bin dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: step to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference decoder: {err, code}.
    function automatic logic [4:0] ref_dec(input logic [14:0] v);
        int n;
        int lo;
        n  = 0;
        lo = 15;
        for (int i = 0; i < 15; i++) begin
            if (v[i]) begin
                if (n == 0) lo = i;
                n++;
            end
        end
        return {(n > 1), 4'(lo)};
    endfunction

    initial begin
        logic        model_full;
        int          acc_multi;
        logic [4:0]  exp_item;
        logic [4:0]  r;

        // Vector table: sweep of one-hot words, all-zero, then multi-hot.
        for (int i = 0; i < 15; i++) begin
            vecs[i] = '{in: 15'(1 << i), out: 4'(i), err: 1'b0, cnt: 8'd0};
        end
        vecs[15] = '{in: 15'h0000, out: 4'hF, err: 1'b0, cnt: 8'd0};
        vecs[16] = '{in: 15'h0024, out: 4'd2, err: 1'b1, cnt: 8'd1};
        vecs[17] = '{in: 15'h7FFF, out: 4'd0, err: 1'b1, cnt: 8'd2};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in        = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out", 32'(out), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset err_cnt", 32'(err_cnt), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Table-driven sweep.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            in = vecs[k].in;
            step();
            chk($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d out", k), 32'(out), 32'(vecs[k].out));
            chk($sformatf("vec%0d out_err", k), 32'(out_err), 32'(vecs[k].err));
            chk($sformatf("vec%0d err_cnt", k), 32'(err_cnt), 32'(vecs[k].cnt));
        end

        // Backpressure.
        in = 15'h0100;
        step();
        chk("bp first out", 32'(out), 32'd8);
        out_ready = 1'b0;
        in        = 15'h0002;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d out held", c), 32'(out), 32'd8);
            chk($sformatf("bp%0d err held", c), 32'(out_err), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp next out", 32'(out), 32'd1);
        chk("bp next valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp drain valid", 32'(out_valid), 32'd0);

        // Saturation and clear.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr err_cnt", 32'(err_cnt), 32'd0);
        in_valid = 1'b1;
        in       = 15'h0003;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 254 || k == 255 || k == 256) begin
                chk($sformatf("sat k=%0d", k), 32'(err_cnt), 32'((k > 255) ? 255 : k));
            end
        end
        chk("sat final", 32'(err_cnt), 32'd255);
        chk("sat out_err", 32'(out_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr with accept", 32'(err_cnt), 32'd0);
        chk("clr accept out", 32'(out), 32'd0);

        // Reset mid-operation.
        in = 15'h0030;
        step();
        chk("pre-rst err_cnt", 32'(err_cnt), 32'd1);
        in        = 15'h0008;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        chk("pre-rst out", 32'(out), 32'd3);
        chk("pre-rst valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst err_cnt", 32'(err_cnt), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in        = 15'h0400;
        step();
        chk("post-rst out", 32'(out), 32'd10);
        chk("post-rst valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();

        // Random stream with scoreboard.
        err_clr = 1'b1;
        step();
        err_clr    = 1'b0;
        model_full = 1'b0;
        acc_multi  = 0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       in = 15'(1 << $urandom_range(0, 14));
                1:       in = 15'h0000;
                default: in = 15'($urandom);
            endcase
            #1;
            chk("rnd in_ready", 32'(in_ready), 32'(!model_full || out_ready));
            chk("rnd out_valid", 32'(out_valid), 32'(model_full));
            if (model_full && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd queue empty", 32'd1, 32'd0);
                end else begin
                    exp_item = exp_q.pop_front();
                    chk("rnd data", 32'({out_err, out}), 32'(exp_item));
                end
            end
            if (in_valid && (!model_full || out_ready)) begin
                r = ref_dec(in);
                exp_q.push_back(r);
                if (r[4]) acc_multi++;
                model_full = 1'b1;
            end else if (out_ready) begin
                model_full = 1'b0;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        if (model_full) begin
            exp_item = exp_q.pop_front();
            chk("rnd last data", 32'({out_err, out}), 32'(exp_item));
        end
        step();
        chk("rnd queue drained", 32'(exp_q.size()), 32'd0);
        chk("rnd err_cnt", 32'(err_cnt), 32'((acc_multi > 255) ? 255 : acc_multi));
        chk("rnd final valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dec_onehot2bin.md
Name: dec_onehot2bin

Overview:
- Registered one-hot-to-binary converter; the inverse of the team's binary-to-one-hot encoder.
- Accepts an N-bit one-hot word under a valid/ready handshake and returns the W-bit index one cycle later.
- Flags malformed (multi-hot) words and keeps a saturating error count.
- Sits on the receive side of one-hot select/grant buses and hands a compact binary code to downstream logic.

Parameters:
- W, 4, binary code width.
- N, 15, one-hot width; must equal 2^W-1. An all-zero word encodes value 2^W-1, matching the encoder, which drives all zeros for that code.
- CNTW, 8, error counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst==0 at a clk edge resets).
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in  input  N  one-hot word.
- out_valid  output  1  out/out_err hold a result.
- out_ready  input  1  downstream accepts the result.
- out  output  W  decoded index.
- out_err  output  1  result came from a multi-hot word.
- err_cnt  output  CNTW  saturating count of accepted multi-hot words.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rst==0 at edge):
  - out_valid=0, out=0, out_err=0, err_cnt=0.
  - in_ready reads 1 in the first cycle after reset.
  - Reset mid-transfer discards any held result; no partial word survives.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single-entry pipeline register).
  - Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k; exactly 1 cycle.
- Throughput: one word per cycle while out_ready=1.
- Hold on stall: while out_valid && !out_ready, out and out_err are stable and in_ready=0; in is ignored.
- Simultaneous transfer and accept: the register loads the new word and out_valid stays 1.
- Transfer with no accept: out_valid goes to 0; out and out_err keep their last values (don't-care).
- Decode rules:
  - Exactly one bit i set: out=i, out_err=0.
  - All zero: out=2^W-1 (15), out_err=0. This is a legal code, not an error.
  - Two or more bits set: out=index of the lowest set bit, out_err=1.
- err_cnt:
  - Increments by 1 on each accepted multi-hot word.
  - Saturates at 2^CNTW-1 and does not wrap.
  - err_clr=1 sets err_cnt to 0 at the edge; err_clr has priority over a simultaneous increment.
  - Counting happens at acceptance time, independent of out_ready.
- Unaccepted cycles (in_valid=0, or in_ready=0) have no effect on the register or the counter.
- No FSM beyond the implied EMPTY/FULL state given by out_valid:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on transfer without accept.
  - FULL to FULL on transfer with accept, or on stall.

Decomposition:
- Shared package enc_pkg holds:
  - ENC_W=4 and ENC_N=15.
  - Typedefs code_t (logic [ENC_W-1:0]) and onehot_t (logic [ENC_N-1:0]).
  - Constant CODE_NONE = 2^ENC_W-1.
- One natural combinational sub-module, onehot_prio_idx. It takes onehot_t and returns:
  - lowest-set index;
  - any (at least one bit set);
  - multi (two or more bits set).
- The top block adds the handshake register and the error counter.

Test Plan:
- Sweep: for i=0..14 drive in=1<<i, in_valid=1, out_ready=1 -> out=i, out_err=0 one cycle later; then in=15'h0000 -> out=4'hF, out_err=0.
- Multi-hot: in=15'h0024 (bits 2 and 5) -> out=2, out_err=1, err_cnt increments 0->1. Then in=15'h7FFF -> out=0, out_err=1, err_cnt=2.
- Backpressure: accept in=15'h0100 and hold out_ready=0 for 3 cycles while presenting in=15'h0002 -> out stays 8 and in_ready=0 for those cycles. Release out_ready -> out=8 transfers and 15'h0002 is accepted the same cycle; out=1 follows one cycle later.
- Saturation and clear: CNTW=8; feed 300 multi-hot words -> err_cnt stops at 255. Assert err_clr together with another multi-hot accept -> err_cnt=0.
- Reset mid-operation: out_valid=1 holding out=3, drive rst=0 for one edge -> out_valid=0, err_cnt=0, in_ready=1 the next cycle. The next word 15'h0400 decodes to 10.
- Random: stream valid and random out_ready against a reference model -> no dropped or duplicated words, order preserved, err_cnt matches the count of accepted multi-hot words.
